adsr_envelope: RTL

- Downstream stage of the square-wave oscillator: consumes the oscillator's offset-binary `square_out` samples and applies an attack/decay/sustain/release amplitude envelope gated by a note-on signal.
- Output is a scaled, offset-binary audio sample for the output DAC/PWM stage.
- Envelope level advances once per prescaled "tick", so the rates are independent of the system clock frequency.

---
 rtl/adsr_envelope.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/adsr_envelope.sv
// ----------------------------------------------------------------------------
// adsr_envelope
//
// Purpose:
//   Applies an attack/decay/sustain/release amplitude envelope to an
//   offset-binary sample stream (typically the square-wave oscillator output)
//   under control of a note-on gate. The envelope level moves once per
//   prescaled tick, so the rates do not depend on the system clock frequency.
//
// Build option:
//   ADSR_EXP_RELEASE_EN  When defined, the release step per tick is
//                        (level >> 3) + 1, giving a pseudo-exponential tail.
//                        release_rate then only selects the instant-release
//                        case (release_rate == 0). Undefined: linear release.
//
// Parameters:
//   resolution_bits  sample width (offset-binary, midpoint 2^(resolution_bits-1))
//   env_bits         envelope level / rate / sustain width
//   tick_div         clock cycles per envelope tick (>= 1)
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   sample_in      oscillator sample, offset-binary
//   gate           note on (1) / off (0), synchronous to clk
//   attack_rate    level increment per tick in attack
//   decay_rate     level decrement per tick in decay
//   sustain_level  decay target and sustain hold level
//   release_rate   level decrement per tick in release
//   audio_out      enveloped sample, offset-binary, registered
//   env_level      current envelope level, registered
//   active         high whenever the envelope is not idle, registered
// ----------------------------------------------------------------------------
module adsr_envelope #(
    parameter int unsigned resolution_bits = 8,
    parameter int unsigned env_bits        = 8,
    parameter int unsigned tick_div        = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [resolution_bits-1:0] sample_in,
    input  logic                       gate,
    input  logic [env_bits-1:0]        attack_rate,
    input  logic [env_bits-1:0]        decay_rate,
    input  logic [env_bits-1:0]        sustain_level,
    input  logic [env_bits-1:0]        release_rate,
    output logic [resolution_bits-1:0] audio_out,
    output logic [env_bits-1:0]        env_level,
    output logic                       active
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int unsigned CntW = (tick_div > 1) ? $clog2(tick_div) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(tick_div - 1);

    // Envelope arithmetic carries one extra bit so overflow/underflow is visible.
    localparam int unsigned EW = env_bits + 1;
    // Signed sample and signed product widths for the scaler.
    localparam int unsigned SW = resolution_bits + 1;
    localparam int unsigned PW = SW + EW;

    localparam logic [resolution_bits-1:0] Mid  = {1'b1, {(resolution_bits-1){1'b0}}};
    localparam logic [env_bits-1:0]        Full = {env_bits{1'b1}};

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StAttack  = 3'd1;
    localparam logic [2:0] StDecay   = 3'd2;
    localparam logic [2:0] StSustain = 3'd3;
    localparam logic [2:0] StRelease = 3'd4;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CntW-1:0]            cnt_q,    cnt_d;
    logic [2:0]                 state_q,  state_d;
    logic [env_bits-1:0]        level_q,  level_d;
    logic                       gate_q;
    logic [resolution_bits-1:0] audio_q,  audio_d;
    logic                       active_q, active_d;

    // ------------------------------------------------------------------------
    // Tick prescaler: free-running, never restarted by the gate
    // ------------------------------------------------------------------------
    logic tick;

    assign tick = (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
            cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Gate edge detection
    // ------------------------------------------------------------------------
    logic gate_rise;
    logic in_note;

    assign gate_rise = gate & ~gate_q;
    assign in_note   = (state_q == StAttack) || (state_q == StDecay) ||
                       (state_q == StSustain);

    // ------------------------------------------------------------------------
    // Saturating envelope arithmetic
    // ------------------------------------------------------------------------
    logic [EW-1:0] lvl_ext;
    logic [EW-1:0] att_sum;
    logic [EW-1:0] dec_diff;
    logic [EW-1:0] rel_step;
    logic [EW-1:0] rel_diff;
    logic          att_full;
    logic          dec_to_sus;
    logic          rel_to_zero;

    always_comb begin
        lvl_ext  = {1'b0, level_q};
        att_sum  = lvl_ext + {1'b0, attack_rate};
        dec_diff = lvl_ext - {1'b0, decay_rate};
`ifdef ADSR_EXP_RELEASE_EN
        rel_step = {1'b0, level_q >> 3} + EW'(1);
`else
        rel_step = {1'b0, release_rate};
`endif
        rel_diff = lvl_ext - rel_step;

        // Rate 0 is an instant jump to the target in every phase.
        att_full    = (attack_rate == '0) || (att_sum >= {1'b0, Full});
        // Borrow out (MSB set) means the subtraction went below zero.
        // Also covers level already below sustain on entry to decay.
        dec_to_sus  = (decay_rate == '0) || dec_diff[env_bits] ||
                      (dec_diff[env_bits-1:0] <= sustain_level);
        rel_to_zero = (release_rate == '0) || rel_diff[env_bits] ||
                      (rel_diff[env_bits-1:0] == '0);
    end

    // ------------------------------------------------------------------------
    // Envelope FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        level_d = level_q;

        if (gate_rise) begin
            // Retrigger from any state; level kept so there is no click.
            state_d = StAttack;
        end else if (!gate && in_note) begin
            state_d = StRelease;
        end else if (tick) begin
            case (state_q)
                StIdle: begin
                    level_d = '0;
                end
                StAttack: begin
                    if (att_full) begin
                        level_d = Full;
                        state_d = StDecay;
                    end else begin
                        level_d = att_sum[env_bits-1:0];
                    end
                end
                StDecay: begin
                    if (dec_to_sus) begin
                        level_d = sustain_level;
                        state_d = StSustain;
                    end else begin
                        level_d = dec_diff[env_bits-1:0];
                    end
                end
                StSustain: begin
                    level_d = sustain_level;
                end
                StRelease: begin
                    if (rel_to_zero) begin
                        level_d = '0;
                        state_d = StIdle;
                    end else begin
                        level_d = rel_diff[env_bits-1:0];
                    end
                end
                default: begin
                    level_d = '0;
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign active_d = (state_d != StIdle);

    // ------------------------------------------------------------------------
    // Sample scaling: audio = M + ((sample - M) * level) >>> env_bits
    // ------------------------------------------------------------------------
    logic signed [SW-1:0] samp_s;
    logic signed [EW-1:0] lvl_s;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_sh;
    logic                 unused_prod_hi;

    always_comb begin
        samp_s  = $signed({1'b0, sample_in}) - $signed({1'b0, Mid});
        lvl_s   = $signed(lvl_ext);
        prod    = PW'(samp_s) * PW'(lvl_s);
        prod_sh = prod >>> env_bits;
        // |prod_sh| never exceeds M, so the low bits carry the full result.
        audio_d = Mid + prod_sh[resolution_bits-1:0];
    end

    assign unused_prod_hi = ^prod_sh[PW-1:resolution_bits];

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            state_q  <= StIdle;
            level_q  <= '0;
            gate_q   <= 1'b0;
            audio_q  <= Mid;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            level_q  <= level_d;
            gate_q   <= gate;
            audio_q  <= audio_d;
            active_q <= active_d;
        end
    end

    assign audio_out = audio_q;
    assign env_level = level_q;
    assign active    = active_q;

endmodule
